// File: rtl/link_txn_fsm_if.sv
// Link transaction bus: PHY/packet-layer events into the sequencer and phase enables and status out of it.
// master drives the events and thresholds; slave is the sequencer side.
interface link_txn_fsm_if #(
  parameter int TIMER_W = 16,
  parameter int DELAY_W = 6,
  parameter int NUM_EP  = 4
);
  localparam int EP_AW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

  logic               ms;
  logic               rx_pid_en;
  logic [3:0]         rx_pid;
  logic               crc5_err;
  logic               rx_sop_en;
  logic               rx_lt_eop_en;
  logic               tx_con_pid_en;
  logic [3:0]         tx_con_pid;
  logic               tx_lp_eop_en;
  logic [EP_AW-1:0]   ep_idx;
  logic [TIMER_W-1:0] time_threshold;
  logic [DELAY_W-1:0] delay_threshold;

  logic               rx_data_on;
  logic               rx_handshake_on;
  logic               tx_data_on;
  logic               d_oe;
  logic               time_out;
  logic               retry_req;
  logic               txn_err;
  logic               data_pid_odd;
  logic [2:0]         state;

  modport master (
    output ms, rx_pid_en, rx_pid, crc5_err, rx_sop_en, rx_lt_eop_en,
           tx_con_pid_en, tx_con_pid, tx_lp_eop_en, ep_idx,
           time_threshold, delay_threshold,
    input  rx_data_on, rx_handshake_on, tx_data_on, d_oe,
           time_out, retry_req, txn_err, data_pid_odd, state
  );

  modport slave (
    input  ms, rx_pid_en, rx_pid, crc5_err, rx_sop_en, rx_lt_eop_en,
           tx_con_pid_en, tx_con_pid, tx_lp_eop_en, ep_idx,
           time_threshold, delay_threshold,
    output rx_data_on, rx_handshake_on, tx_data_on, d_oe,
           time_out, retry_req, txn_err, data_pid_odd, state
  );
endinterface

// File: rtl/link_txn_fsm.sv
// Link transaction sequencer (token/data/turnaround/handshake) for master and slave roles; LINK_TOGGLE_EN adds DATA0/DATA1 tracking.
// State and pulses change one cycle after the triggering event; no backpressure, events are single-cycle pulses.
module link_txn_fsm #(
  parameter int TIMER_W   = 16,
  parameter int DELAY_W   = 6,
  parameter int MAX_RETRY = 3,
  parameter int NUM_EP    = 4
) (
  input logic            clk,
  input logic            rst_n,
  link_txn_fsm_if.slave  bus
);
  localparam int EP_AW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
  localparam int RC_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RC_W-1:0] MAX_RC = RC_W'(MAX_RETRY);

  localparam logic [3:0] PID_OUT = 4'b0001;
  localparam logic [3:0] PID_IN  = 4'b1001;
  localparam logic [3:0] PID_ACK = 4'b0010;
  localparam logic [3:0] PID_NAK = 4'b1010;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TOKEN   = 3'd1,
    DATA_TX = 3'd2,
    DATA_RX = 3'd3,
    TURN    = 3'd4,
    HS_RX   = 3'd5,
    HS_TX   = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic               txn_tx_q, txn_tx_d;     // this side sends the data packet
  logic               sop_seen_q, sop_seen_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [RC_W-1:0]    retry_q, retry_d;
  logic               time_out_q, time_out_d;
  logic               retry_req_q, retry_req_d;
  logic               txn_err_q, txn_err_d;
  logic               drive_q;

  logic               is_ack, is_nak, tmo_hit;
  logic               tok_start, data_rx_done, ack_done;

  assign is_ack  = bus.rx_pid_en && (bus.rx_pid == PID_ACK);
  assign is_nak  = bus.rx_pid_en && (bus.rx_pid == PID_NAK);
  assign tmo_hit = ((state_q == DATA_RX) || (state_q == HS_RX)) &&
                   (bus.time_threshold != '0) && (timer_q == bus.time_threshold);

  always_comb begin
    state_d      = state_q;
    txn_tx_d     = txn_tx_q;
    retry_d      = retry_q;
    time_out_d   = 1'b0;
    retry_req_d  = 1'b0;
    txn_err_d    = 1'b0;
    tok_start    = 1'b0;
    data_rx_done = 1'b0;
    ack_done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ms) begin
          if (bus.tx_con_pid_en && ((bus.tx_con_pid == PID_OUT) || (bus.tx_con_pid == PID_IN))) begin
            state_d   = TOKEN;
            txn_tx_d  = (bus.tx_con_pid == PID_OUT);
            tok_start = 1'b1;
          end
        end else if (bus.rx_pid_en && !bus.crc5_err &&
                     ((bus.rx_pid == PID_OUT) || (bus.rx_pid == PID_IN))) begin
          state_d   = (bus.rx_pid == PID_OUT) ? DATA_RX : DATA_TX;
          txn_tx_d  = (bus.rx_pid == PID_IN);
          tok_start = 1'b1;
        end
      end
      TOKEN:   if (bus.tx_lp_eop_en) state_d = txn_tx_q ? DATA_TX : TURN;
      DATA_TX: if (bus.tx_lp_eop_en) state_d = TURN;
      TURN:    if (delay_q == bus.delay_threshold) state_d = txn_tx_q ? HS_RX : DATA_RX;
      DATA_RX: begin
        if (bus.rx_lt_eop_en) begin
          state_d      = HS_TX;
          data_rx_done = 1'b1;
        end else if (tmo_hit) begin
          state_d    = IDLE;
          time_out_d = 1'b1;
        end
      end
      HS_RX: begin
        // ACK beats a timeout landing in the same cycle
        if (is_ack) begin
          state_d  = IDLE;
          retry_d  = '0;
          ack_done = 1'b1;
        end else if (tmo_hit || is_nak) begin
          state_d    = IDLE;
          time_out_d = tmo_hit;
          if (bus.ms) begin
            if (retry_q < MAX_RC) begin
              retry_d     = retry_q + 1'b1;
              retry_req_d = 1'b1;
            end else begin
              retry_d   = '0;
              txn_err_d = 1'b1;
            end
          end
        end
      end
      HS_TX:   if (bus.tx_lp_eop_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Timeout timer: runs while waiting for a handshake or for a data packet to start
  always_comb begin
    timer_d    = timer_q;
    sop_seen_d = sop_seen_q;
    delay_d    = delay_q;

    if ((state_d != state_q) && ((state_d == DATA_RX) || (state_d == HS_RX))) begin
      timer_d    = '0;
      sop_seen_d = 1'b0;
    end else if (bus.rx_sop_en) begin
      timer_d = '0;
      if (state_q == DATA_RX) sop_seen_d = 1'b1;
    end else if (((state_q == HS_RX) || ((state_q == DATA_RX) && !sop_seen_q)) && (timer_q != '1)) begin
      timer_d = timer_q + 1'b1;
    end

    if ((state_d == TURN) && (state_q != TURN)) delay_d = '0;
    else if (state_q == TURN)                   delay_d = delay_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      txn_tx_q    <= 1'b0;
      sop_seen_q  <= 1'b0;
      timer_q     <= '0;
      delay_q     <= '0;
      retry_q     <= '0;
      time_out_q  <= 1'b0;
      retry_req_q <= 1'b0;
      txn_err_q   <= 1'b0;
      drive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      txn_tx_q    <= txn_tx_d;
      sop_seen_q  <= sop_seen_d;
      timer_q     <= timer_d;
      delay_q     <= delay_d;
      retry_q     <= retry_d;
      time_out_q  <= time_out_d;
      retry_req_q <= retry_req_d;
      txn_err_q   <= txn_err_d;
      drive_q     <= (state_d == DATA_TX) || (state_d == HS_TX);
    end
  end

  // Idle/token drive follows ms straight off the state register so reset yields d_oe == ms
  assign bus.d_oe            = drive_q | (bus.ms & ((state_q == IDLE) || (state_q == TOKEN)));
  assign bus.rx_data_on      = (state_q == DATA_RX);
  assign bus.rx_handshake_on = (state_q == HS_RX);
  assign bus.tx_data_on      = (state_q == DATA_TX);
  assign bus.time_out        = time_out_q;
  assign bus.retry_req       = retry_req_q;
  assign bus.txn_err         = txn_err_q;
  assign bus.state           = state_q;

`ifdef LINK_TOGGLE_EN
  logic [NUM_EP-1:0] toggle_q;
  logic [EP_AW-1:0]  ep_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_q <= '0;
      ep_q     <= '0;
    end else begin
      if (tok_start) ep_q <= bus.ep_idx;
      if (ack_done || data_rx_done) toggle_q[ep_q] <= ~toggle_q[ep_q];
    end
  end

  assign bus.data_pid_odd = toggle_q[ep_q];
`else
  logic unused_toggle;
  assign unused_toggle    = ^{bus.ep_idx, tok_start, data_rx_done, ack_done};
  assign bus.data_pid_odd = 1'b0;
`endif

endmodule

// File: tb/tb_link_txn_fsm.sv
// Directed bench for link_txn_fsm: vector table for the main flows plus hand sequences for timing corners.
module tb_link_txn_fsm;
  localparam int TIMER_W = 16;
  localparam int DELAY_W = 6;
  localparam int NUM_EP  = 4;

  localparam int EV_NONE = 0;
  localparam int EV_TXT  = 1;
  localparam int EV_RXP  = 2;
  localparam int EV_SOP  = 3;
  localparam int EV_RXE  = 4;
  localparam int EV_TXE  = 5;

  localparam logic [3:0] P_OUT = 4'b0001;
  localparam logic [3:0] P_IN  = 4'b1001;
  localparam logic [3:0] P_ACK = 4'b0010;
  localparam logic [3:0] P_NAK = 4'b1010;
  localparam logic [3:0] P_D0  = 4'b0011;
  localparam logic [3:0] P_SOF = 4'b0101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  link_txn_fsm_if #(.TIMER_W(TIMER_W), .DELAY_W(DELAY_W), .NUM_EP(NUM_EP)) bus ();

  link_txn_fsm #(.TIMER_W(TIMER_W), .DELAY_W(DELAY_W), .MAX_RETRY(3), .NUM_EP(NUM_EP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       ms;
    int         ev;
    logic [3:0] pid;
    logic       crc;
    logic [2:0] st;
    logic       doe;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    bus.rx_pid_en     = 1'b0;
    bus.rx_pid        = 4'b0000;
    bus.crc5_err      = 1'b0;
    bus.rx_sop_en     = 1'b0;
    bus.rx_lt_eop_en  = 1'b0;
    bus.tx_con_pid_en = 1'b0;
    bus.tx_con_pid    = 4'b0000;
    bus.tx_lp_eop_en  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int ev, input logic [3:0] pid, input logic crc);
    case (ev)
      EV_TXT: begin bus.tx_con_pid_en = 1'b1; bus.tx_con_pid = pid; end
      EV_RXP: begin bus.rx_pid_en = 1'b1; bus.rx_pid = pid; bus.crc5_err = crc; end
      EV_SOP: bus.rx_sop_en = 1'b1;
      EV_RXE: bus.rx_lt_eop_en = 1'b1;
      EV_TXE: bus.tx_lp_eop_en = 1'b1;
      default: ;
    endcase
    tick();
    clear_in();
  endtask

  function automatic vec_t mk(input logic ms, input int ev, input logic [3:0] pid,
                              input logic crc, input logic [2:0] st, input logic doe);
    vec_t v;
    v.ms = ms; v.ev = ev; v.pid = pid; v.crc = crc; v.st = st; v.doe = doe;
    return v;
  endfunction

  function automatic logic [9:0] outs_now();
    return {bus.state, bus.d_oe, bus.rx_data_on, bus.rx_handshake_on, bus.tx_data_on,
            bus.time_out, bus.retry_req, bus.txn_err};
  endfunction

  task automatic out_to_hs();
    bus.ms = 1'b1;
    step(EV_TXT, P_OUT, 1'b0);
    step(EV_TXE, 4'b0, 1'b0);
    step(EV_TXE, 4'b0, 1'b0);
    for (int n = 0; n < 80 && bus.state != 3'd5; n++) tick();
    check("reach_hs_rx", bus.state, 32'd5);
  endtask

  // Timer clears on HS_RX entry and hits 10 after ten further cycles; the pulse and IDLE appear one edge later.
  task automatic do_timeout(input string name, input logic exp_rty, input logic exp_err);
    out_to_hs();
    repeat (10) tick();
    check({name, "_pre"}, {bus.state, bus.time_out}, {3'd5, 1'b0});
    tick();
    check(name, {bus.state, bus.time_out, bus.retry_req, bus.txn_err}, {3'd0, 1'b1, exp_rty, exp_err});
    tick();
    check({name, "_pulse_end"}, {bus.time_out, bus.retry_req, bus.txn_err}, 32'd0);
  endtask

  task automatic acked_out(input logic [1:0] ep, output logic odd);
    bus.ms = 1'b1;
    bus.ep_idx = ep;
    step(EV_TXT, P_OUT, 1'b0);
    step(EV_TXE, 4'b0, 1'b0);
    odd = bus.data_pid_odd;
    step(EV_TXE, 4'b0, 1'b0);
    tick();
    step(EV_RXP, P_ACK, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic odd;
    logic tog;
`ifdef LINK_TOGGLE_EN
    tog = 1'b1;
`else
    tog = 1'b0;
`endif

    // Master OUT with a non-handshake PID ignored in HS_RX
    vt.push_back(mk(1, EV_TXT,  P_OUT, 0, 3'd1, 1));
    vt.push_back(mk(1, EV_NONE, 4'b0,  0, 3'd1, 1));
    vt.push_back(mk(1, EV_TXE,  4'b0,  0, 3'd2, 1));
    vt.push_back(mk(1, EV_TXE,  4'b0,  0, 3'd4, 0));
    vt.push_back(mk(1, EV_NONE, 4'b0,  0, 3'd4, 0));
    vt.push_back(mk(1, EV_NONE, 4'b0,  0, 3'd4, 0));
    vt.push_back(mk(1, EV_NONE, 4'b0,  0, 3'd4, 0));
    vt.push_back(mk(1, EV_NONE, 4'b0,  0, 3'd5, 0));
    vt.push_back(mk(1, EV_RXP,  P_D0,  0, 3'd5, 0));
    vt.push_back(mk(1, EV_RXP,  P_ACK, 0, 3'd0, 1));
    vt.push_back(mk(1, EV_TXT,  P_SOF, 0, 3'd0, 1));
    // Master IN, with a token start ignored outside IDLE
    vt.push_back(mk(1, EV_TXT,  P_IN,  0, 3'd1, 1));
    vt.push_back(mk(1, EV_TXE,  4'b0,  0, 3'd4, 0));
    vt.push_back(mk(1, EV_NONE, 4'b0,  0, 3'd4, 0));
    vt.push_back(mk(1, EV_NONE, 4'b0,  0, 3'd4, 0));
    vt.push_back(mk(1, EV_NONE, 4'b0,  0, 3'd4, 0));
    vt.push_back(mk(1, EV_NONE, 4'b0,  0, 3'd3, 0));
    vt.push_back(mk(1, EV_SOP,  4'b0,  0, 3'd3, 0));
    vt.push_back(mk(1, EV_RXE,  4'b0,  0, 3'd6, 1));
    vt.push_back(mk(1, EV_TXT,  P_OUT, 0, 3'd6, 1));
    vt.push_back(mk(1, EV_TXE,  4'b0,  0, 3'd0, 1));
    // Slave IN: CRC-bad token and TX token ignored, then a clean one
    vt.push_back(mk(0, EV_RXP,  P_IN,  1, 3'd0, 0));
    vt.push_back(mk(0, EV_TXT,  P_OUT, 0, 3'd0, 0));
    vt.push_back(mk(0, EV_RXP,  P_IN,  0, 3'd2, 1));
    vt.push_back(mk(0, EV_RXP,  P_OUT, 0, 3'd2, 1));
    vt.push_back(mk(0, EV_TXE,  4'b0,  0, 3'd4, 0));
    vt.push_back(mk(0, EV_NONE, 4'b0,  0, 3'd4, 0));
    vt.push_back(mk(0, EV_NONE, 4'b0,  0, 3'd4, 0));
    vt.push_back(mk(0, EV_NONE, 4'b0,  0, 3'd4, 0));
    vt.push_back(mk(0, EV_NONE, 4'b0,  0, 3'd5, 0));
    vt.push_back(mk(0, EV_RXP,  P_ACK, 0, 3'd0, 0));
    // Slave OUT
    vt.push_back(mk(0, EV_RXP,  P_OUT, 1, 3'd0, 0));
    vt.push_back(mk(0, EV_RXP,  P_OUT, 0, 3'd3, 0));
    vt.push_back(mk(0, EV_SOP,  4'b0,  0, 3'd3, 0));
    vt.push_back(mk(0, EV_RXE,  4'b0,  0, 3'd6, 1));
    vt.push_back(mk(0, EV_TXE,  4'b0,  0, 3'd0, 0));

    clear_in();
    bus.ms = 1'b1;
    bus.ep_idx = 2'd2;
    bus.time_threshold = '0;
    bus.delay_threshold = 6'd3;
    #12;
    check("reset_outs_ms1", {outs_now(), bus.data_pid_odd}, {3'd0, 1'b1, 6'b0, 1'b0});
    bus.ms = 1'b0;
    #1;
    check("reset_doe_ms0", bus.d_oe, 32'd0);
    bus.ms = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", outs_now(), {3'd0, 1'b1, 6'b0});

    foreach (vt[i]) begin
      bus.ms = vt[i].ms;
      step(vt[i].ev, vt[i].pid, vt[i].crc);
      check($sformatf("vec%0d", i), outs_now(),
            {vt[i].st, vt[i].doe, vt[i].st == 3'd3, vt[i].st == 3'd5, vt[i].st == 3'd2, 3'b000});
    end

    // Zero turnaround gives a single TURN cycle
    bus.delay_threshold = '0;
    bus.ms = 1'b1;
    step(EV_TXT, P_OUT, 1'b0);
    step(EV_TXE, 4'b0, 1'b0);
    step(EV_TXE, 4'b0, 1'b0);
    check("turn0_in_turn", bus.state, 32'd4);
    tick();
    check("turn0_hs_rx", bus.state, 32'd5);
    step(EV_RXP, P_ACK, 1'b0);
    check("turn0_ack", bus.state, 32'd0);

    // Retry budget, ACK/timeout collision, and retry counter clearing
    bus.time_threshold = 16'd10;
    do_timeout("tmo1", 1'b1, 1'b0);
    do_timeout("tmo2", 1'b1, 1'b0);
    do_timeout("tmo3", 1'b1, 1'b0);
    do_timeout("tmo4", 1'b0, 1'b1);
    do_timeout("tmo5", 1'b1, 1'b0);
    out_to_hs();
    repeat (10) tick();
    step(EV_RXP, P_ACK, 1'b0);
    check("ack_beats_tmo", {bus.state, bus.time_out, bus.retry_req, bus.txn_err}, 32'd0);
    do_timeout("tmo6", 1'b1, 1'b0);
    do_timeout("tmo7", 1'b1, 1'b0);
    do_timeout("tmo8", 1'b1, 1'b0);
    do_timeout("tmo9", 1'b0, 1'b1);
    out_to_hs();
    step(EV_RXP, P_NAK, 1'b0);
    check("nak_retry", {bus.state, bus.time_out, bus.retry_req, bus.txn_err}, {3'd0, 1'b0, 1'b1, 1'b0});

    // Slave waiting for data: timeout, and rx_sop_en stopping the timer
    bus.ms = 1'b0;
    step(EV_RXP, P_OUT, 1'b0);
    repeat (10) tick();
    check("slv_tmo_pre", {bus.state, bus.time_out}, {3'd3, 1'b0});
    tick();
    check("slv_tmo", {bus.state, bus.time_out, bus.retry_req, bus.txn_err}, {3'd0, 1'b1, 1'b0, 1'b0});
    step(EV_RXP, P_OUT, 1'b0);
    repeat (5) tick();
    step(EV_SOP, 4'b0, 1'b0);
    repeat (20) tick();
    check("sop_holds_timer", {bus.state, bus.time_out}, {3'd3, 1'b0});
    step(EV_RXE, 4'b0, 1'b0);
    step(EV_TXE, 4'b0, 1'b0);
    check("slv_out_done", bus.state, 32'd0);

    // Asynchronous reset in the middle of DATA_RX
    bus.time_threshold = '0;
    bus.ms = 1'b1;
    step(EV_TXT, P_IN, 1'b0);
    step(EV_TXE, 4'b0, 1'b0);
    tick();
    check("pre_arst_data_rx", bus.state, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_outs", {bus.state, bus.rx_data_on, bus.d_oe}, {3'd0, 1'b0, 1'b1});
    bus.ms = 1'b0;
    #1;
    check("arst_doe_ms0", bus.d_oe, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.ms = 1'b1;
    tick();

    // Data toggle per endpoint
    acked_out(2'd2, odd);
    check("tog_ep2_first", odd, 32'd0);
    acked_out(2'd2, odd);
    check("tog_ep2_second", odd, {31'd0, tog});
    acked_out(2'd1, odd);
    check("tog_ep1", odd, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/link_txn_fsm.md
LINK_TXN_FSM -- requirements
Module: link_txn_fsm

Interface
REQ-001 SHALL have parameter TIMER_W, default 16: timeout timer width.
REQ-002 SHALL have parameter DELAY_W, default 6: turnaround counter width.
REQ-003 SHALL have parameter MAX_RETRY, default 3: master retries before txn_err.
REQ-004 SHALL have parameter NUM_EP, default 4: endpoint count; EP_AW = clog2(NUM_EP), minimum 1.
REQ-005 SHALL have ports as follows; one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- ms  in  1  1=master, 0=slave
- rx_pid_en  in  1  received-PID pulse, end of packet
- rx_pid  in  4  received PID
- crc5_err  in  1  token CRC5 error, valid with rx_pid_en
- rx_sop_en  in  1  data-packet start pulse
- rx_lt_eop_en  in  1  data-packet end pulse
- tx_con_pid_en  in  1  TX token start pulse
- tx_con_pid  in  4  TX token PID
- tx_lp_eop_en  in  1  TX packet end pulse
- ep_idx  in  EP_AW  endpoint, sampled at transaction start
- time_threshold  in  TIMER_W  timeout value; 0 disables
- delay_threshold  in  DELAY_W  turnaround cycles
- rx_data_on, rx_handshake_on, tx_data_on  out  1  enables, high in DATA_RX / HS_RX / DATA_TX
- d_oe  out  1  bus drive enable
- time_out, retry_req, txn_err  out  1  one-cycle pulses
- data_pid_odd  out  1  1=DATA1 expected/sent
- state  out  3  current FSM state

Function
REQ-006 SHALL implement registered FSM with encodings IDLE=0, TOKEN=1, DATA_TX=2, DATA_RX=3, TURN=4, HS_RX=5, HS_TX=6; 7 unreachable, recovers to IDLE next cycle.
REQ-007 Master OUT (tx_con_pid_en, PID 0001, IDLE): IDLE->TOKEN->DATA_TX on tx_lp_eop_en->TURN on tx_lp_eop_en->HS_RX on delay done->IDLE on ACK (0010).
REQ-008 Master IN (PID 1001): IDLE->TOKEN->TURN on tx_lp_eop_en->DATA_RX->HS_TX on rx_lt_eop_en->IDLE on tx_lp_eop_en.
REQ-009 Slave: rx_pid_en, crc5_err=0, PID 0001 -> DATA_RX->HS_TX on rx_lt_eop_en->IDLE on tx_lp_eop_en; PID 1001 -> DATA_TX->TURN->HS_RX->IDLE on ACK.
REQ-010 Token start events outside IDLE, or with crc5_err=1, SHALL be ignored.
REQ-011 TURN SHALL last delay_threshold+1 cycles; delay_threshold=0 gives one cycle.
REQ-012 d_oe registered: 1 in DATA_TX and HS_TX; 1 in IDLE and TOKEN when ms=1; 0 otherwise.
REQ-013 Timer SHALL clear on entering DATA_RX/HS_RX and on rx_sop_en, count in HS_RX and in DATA_RX before rx_sop_en, hold elsewhere.
REQ-014 Timer == time_threshold (nonzero) SHALL pulse time_out and return FSM to IDLE next cycle.
REQ-015 Master time_out or NAK (1010) in HS_RX: retry_cnt < MAX_RETRY -> increment, pulse retry_req; else pulse txn_err, clear retry_cnt. ACK SHALL clear retry_cnt.
REQ-016 ACK and timeout in the same cycle: ACK wins, no time_out pulse.
REQ-017 Non-ACK/NAK PID in HS_RX SHALL be ignored; timer continues.
REQ-018 Timer SHALL saturate at all-ones.

Reset
REQ-019 rst_n low, any state: state=IDLE, timer, delay and retry counters 0, pulses 0, enables 0, toggle bits 0.
REQ-020 d_oe reset value SHALL equal ms.

Configuration
REQ-021 Macro LINK_TOGGLE_EN defined: NUM_EP toggle bits; data_pid_odd = bit of latched ep_idx; bit flips on ACK ending DATA_TX transaction and on rx_lt_eop_en ending DATA_RX.
REQ-022 LINK_TOGGLE_EN undefined: no toggle storage, data_pid_odd tied 0, all else identical.

Verification
REQ-023 ms=1, OUT token, two tx_lp_eop_en, delay_threshold=3, ACK -> states 1,2,4(4 cycles),5,0; d_oe 0 only in TURN/HS_RX.
REQ-024 ms=1, OUT, time_threshold=10, no ACK -> time_out 10 cycles into HS_RX; 4th timeout gives txn_err, not retry_req.
REQ-025 ms=0, IN token with crc5_err=1 -> state stays 0; crc5_err=0 -> state 2, tx_data_on=1.
REQ-026 ACK and timer==threshold same cycle -> IDLE, time_out=0, retry_cnt=0.
REQ-027 rst_n low mid DATA_RX -> state 0, rx_data_on 0, d_oe=ms, asynchronously.
REQ-028 LINK_TOGGLE_EN, ep_idx=2, two acked OUTs -> data_pid_odd 0 then 1; ep_idx=1 stays 0.
